mux_rr: RTL

MUX_RR -- requirements
Module: mux_rr

---
 rtl/mux_rr.sv | 63 ++++++
 1 files changed

// File: rtl/mux_rr.sv
// mux_rr: N-to-1 channel mux with a fixed-select or round-robin grant
// and a single registered output stage (valid/ready on both sides).
module mux_rr #(
  parameter int WIDTH = 8,
  parameter int N = 4,
  parameter int SW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic             mode,
  input  logic [SW-1:0]    sel,
  output logic [WIDTH-1:0] out_data,
  output logic [SW-1:0]    out_ch,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [SW-1:0] ptr_q, ptr_d, ch_q, ch_d, g, k;
  logic [WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d, hit, take;
  always_comb begin
    g = '0;
    k = '0;
    hit = 1'b0;
    if (mode) begin
      // scan downward so the last hit written is the first valid at or after ptr
      for (int i = N - 1; i >= 0; i--) begin
        k = SW'((int'(ptr_q) + i) % N);
        if (1'(in_valid >> k)) begin
          g = k;
          hit = 1'b1;
        end
      end
    end else begin
      g = sel;
      hit = 1'(in_valid >> sel);
    end
    take = rst_n && hit && (!valid_q || out_ready);
    in_ready = take ? N'(1) << g : '0;
    valid_d = take || (valid_q && !out_ready);
    data_d = take ? WIDTH'(in_data >> (int'(g) * WIDTH)) : data_q;
    ch_d = take ? g : ch_q;
    ptr_d = (take && mode) ? SW'((int'(g) + 1) % N) : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q <= '0;
      ch_q <= '0;
      ptr_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
      ch_q <= ch_d;
      ptr_q <= ptr_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data = data_q;
  assign out_ch = ch_q;
endmodule
